// File: rtl/jk_counter_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification helpers
// for the JK counter controller.
package jk_counter_ctrl_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_UP     = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_INVERT = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    function automatic logic is_count_op(input logic [2:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op > OP_INVERT);
    endfunction

endpackage

// File: rtl/jk_counter_ctrl_cell.sv
// Single JK flip-flop with synchronous active-high reset
// (00 hold, 01 reset, 10 set, 11 toggle).
module jk_sync_res (
    input  logic clk,
    input  logic sync_reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // JK next-state function
    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer for a WIDTH-bit JK register: accepts one command at a time,
// drives per-bit J/K pairs from the latched op and current q, and reports completion.
module jk_counter_ctrl
    import jk_counter_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic [WIDTH-1:0]  q,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              err
);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                done_q, done_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;

    logic [WIDTH-1:0]    j_s, k_s;
    logic [WIDTH-1:0]    up_t_s, dn_t_s;
    logic                ones_below_s, zeros_below_s;
    logic                counting_s;

    assign counting_s = is_count_op(op_q) && (rem_q != {STEP_W{1'b0}});

    // toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        up_t_s        = {WIDTH{1'b0}};
        dn_t_s        = {WIDTH{1'b0}};
        ones_below_s  = 1'b1;
        zeros_below_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t_s[i]     = ones_below_s;
            dn_t_s[i]     = zeros_below_s;
            ones_below_s  = ones_below_s & q[i];
            zeros_below_s = zeros_below_s & ~q[i];
        end
    end

    // per-bit J/K drive; everything holds outside EXEC
    always_comb begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_CLEAR: begin
                    j_s = {WIDTH{1'b0}};
                    k_s = {WIDTH{1'b1}};
                end
                OP_LOAD: begin
                    j_s = data_q;
                    k_s = ~data_q;
                end
                OP_INVERT: begin
                    j_s = {WIDTH{1'b1}};
                    k_s = {WIDTH{1'b1}};
                end
                OP_UP: begin
                    j_s = counting_s ? up_t_s : {WIDTH{1'b0}};
                    k_s = counting_s ? up_t_s : {WIDTH{1'b0}};
                end
                OP_DOWN: begin
                    j_s = counting_s ? dn_t_s : {WIDTH{1'b0}};
                    k_s = counting_s ? dn_t_s : {WIDTH{1'b0}};
                end
                default: begin
                    j_s = {WIDTH{1'b0}};
                    k_s = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            j_s = {WIDTH{1'b0}};
            k_s = {WIDTH{1'b0}};
        end
    end

    // FSM next state and completion flags
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_EXEC;
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    rem_d   = cmd_steps;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (counting_s) begin
                    rem_d  = rem_q - {{(STEP_W-1){1'b0}}, 1'b1};
                    // wrap flags the cycle in which q shows the wrapped value
                    wrap_d = (op_q == OP_UP) ? (&q) : ~(|q);
                    if (rem_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = is_illegal_op(op_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // controller registers; reset aborts any command without a done pulse
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= {WIDTH{1'b0}};
            rem_q   <= {STEP_W{1'b0}};
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_sync_res u_cell (
            .clk        (clk),
            .sync_reset (sync_reset),
            .j          (j_s[i]),
            .k          (k_s[i]),
            .q          (q[i])
        );
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_EXEC);
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Command-driven controller that sequences a WIDTH-bit register built from one jk_sync_res cell per bit.
- Accepts one command at a time over a valid/ready handshake: clear, load, invert, or count up/down for N steps.
- For each command it generates the per-bit J/K pair and signals completion.
- Sits between a stimulus/host FSM and the JK register bank, as the sequencer for the lab's JK-based counters.

Parameters:
WIDTH, 4, register width in bits (number of JK cells), >=2
STEP_W, 8, width of the step-count field

Ports:
clk  input  1  rising-edge clock
sync_reset  input  1  synchronous active-high reset, sampled on posedge clk
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  3  0 NOP, 1 CLEAR, 2 LOAD, 3 UP, 4 DOWN, 5 INVERT, 6-7 illegal
cmd_data  input  WIDTH  load value (LOAD only)
cmd_steps  input  STEP_W  number of count steps (UP/DOWN only)
q  output  WIDTH  JK register contents
busy  output  1  high while in EXEC
done  output  1  one-cycle completion pulse
wrap  output  1  one-cycle pulse, q just wrapped during a count
err  output  1  one-cycle pulse with done, illegal opcode

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on sync_reset.
- Reset values (sync_reset high at a posedge): q=0 (sync_reset drives every JK cell), state=IDLE, cmd_ready=1, busy=0, done=0, wrap=0, err=0.
- Reset mid-EXEC: aborts the command with no done pulse. Reset has priority over every other event.
- States: IDLE and EXEC.
- IDLE -> EXEC: on a posedge with cmd_valid && cmd_ready.
  - At that edge, latch op, data and steps (remaining := cmd_steps).
  - cmd_ready=0 and busy=1 from the next cycle.
  - Held commands are not re-sampled while busy.
- J/K drive is combinational from the latched op and the current q.
  - In IDLE, all J=K=0 (hold).
  - CLEAR: J=0, K=1 on all bits.
  - LOAD: J=data[i], K=~data[i].
  - INVERT: J=K=1.
  - UP: J=K=&q[i-1:0]; bit0 always toggles.
  - DOWN: J=K=~|q[i-1:0].
  - NOP and illegal ops: J=K=0.
- Single-shot ops (NOP, CLEAR, LOAD, INVERT, illegal): EXEC lasts exactly 1 cycle.
  - q updates at the end-of-EXEC edge; the FSM returns to IDLE at that edge.
  - done=1 in the first IDLE cycle, coincident with the new q and with cmd_ready=1.
  - Latency, accept edge to done: 2 edges.
- UP/DOWN with steps=n>0: EXEC lasts n cycles; q changes by ±1 mod 2^WIDTH at each EXEC edge; remaining decrements.
  - Leave EXEC at the edge where remaining==1.
  - done follows in the next cycle, as for single-shot ops.
- UP/DOWN with steps=0: one EXEC cycle with hold J/K; q unchanged; done as for single-shot ops.
- wrap: registered; high for the one cycle in which q displays the wrapped value. This is all-ones -> 0 for UP, 0 -> all-ones for DOWN.
  - Can pulse multiple times in one command when n > 2^WIDTH.
- err: high with done when the latched op was 6 or 7. No state change results.
- A new command may be accepted in the same cycle done is high: back-to-back operation with one IDLE cycle between commands.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_NOP, OP_CLEAR, OP_LOAD, OP_UP, OP_DOWN, OP_INVERT;
  - state encoding: ST_IDLE, ST_EXEC.
- Sub-module: the existing jk_sync_res cell, instantiated WIDTH times via generate.
  - clk and sync_reset are shared by all cells.
  - The controller only produces J[i]/K[i] and never writes q directly.

Test Plan:
- Reset: sync_reset=1 for 2 cycles with q previously 4'b1010 -> q=0, cmd_ready=1, done=wrap=err=0.
- LOAD: cmd_data=4'hB -> q=4'hB two edges after accept, done pulse 1 cycle. Then INVERT -> q=4'h4.
- UP: from q=4'hE with steps=3 -> q goes E, F, 0, 1 on successive edges; wrap high only in the cycle q=0; done after q=1; busy high 3 cycles.
- DOWN: from q=4'h1 with steps=2 -> q=0, then F; wrap with F. Then steps=0 -> q stays F, done after 2 edges.
- Illegal op 7 after LOAD 4'h5 -> q stays 5, done and err together. Then back-to-back CLEAR accepted in the done cycle -> q=0.
- sync_reset asserted in the 2nd EXEC cycle of UP steps=10 -> q=0 at that edge, IDLE, no done. The next command is accepted normally.
